// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard controller.
// Holds the select-width function, the stall-cause codes and the load-use FSM states.
package fwd_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        LU_WAIT = 1'b1
    } lu_state_t;

    // A cause of 2'b11 means both terms are active; it is formed by OR-ing these codes.
    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_LOAD = 2'b01;
    localparam logic [1:0] CAUSE_SB   = 2'b10;

    function automatic int sel_width(input int num_stage);
        return (num_stage < 1) ? 1 : $clog2(num_stage + 1);
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Forward-select priority encoder for one EX source operand.
// The nearest writing stage (lowest index) wins; x0 never forwards.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int NUM_STAGE = 2
) (
    input  logic [REG_AW-1:0]                 i_ex_rs,
    input  logic [NUM_STAGE-1:0]              i_stg_regwrite,
    input  logic [NUM_STAGE-1:0]              i_stg_link,
    input  logic [NUM_STAGE*REG_AW-1:0]       i_stg_rd,
    output logic [sel_width(NUM_STAGE)-1:0]   o_sel,
    output logic                              o_link
);

    localparam int SELW = sel_width(NUM_STAGE);

    // Scan oldest to nearest so the nearest match overwrites older ones.
    always_comb begin
        o_sel  = '0;
        o_link = 1'b0;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            if (i_stg_regwrite[k] &&
                (i_stg_rd[k*REG_AW +: REG_AW] != '0) &&
                (i_stg_rd[k*REG_AW +: REG_AW] == i_ex_rs)) begin
                o_sel  = SELW'(k + 1);
                o_link = i_stg_link[k];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: per-source forward selects, load-use stall FSM,
// pending-write scoreboard for long-latency units and a saturating stall counter.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int NUM_STAGE = 2,
    parameter int LOAD_LAT  = 1,
    parameter int CNT_W     = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    flush,
    input  logic                                    id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]               id_rs,
    input  logic [NUM_SRC-1:0]                      id_rs_used,
    input  logic [NUM_SRC*REG_AW-1:0]               ex_rs,
    input  logic                                    ex_regwrite,
    input  logic                                    ex_memread,
    input  logic [REG_AW-1:0]                       ex_rd,
    input  logic [NUM_STAGE-1:0]                    stg_regwrite,
    input  logic [NUM_STAGE-1:0]                    stg_link,
    input  logic [NUM_STAGE*REG_AW-1:0]             stg_rd,
    input  logic                                    lat_issue,
    input  logic [REG_AW-1:0]                       lat_rd,
    input  logic                                    lat_done,
    input  logic [REG_AW-1:0]                       lat_done_rd,
    output logic [NUM_SRC*sel_width(NUM_STAGE)-1:0] fwd_sel,
    output logic [NUM_SRC-1:0]                      fwd_link,
    output logic                                    stall,
    output logic [1:0]                              stall_cause,
    output logic [CNT_W-1:0]                        stall_cnt
);

    localparam int SELW = sel_width(NUM_STAGE);
    localparam int NREG = 2 ** REG_AW;
    localparam int WCW  = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    lu_state_t        r_state, w_state_nxt;
    logic [WCW-1:0]   r_wait_cnt, w_wait_nxt;
    logic [NREG-1:0]  r_pending, w_pending_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_lu_hit, w_sb_hit, w_lu_term, w_stall;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_match #(
            .REG_AW    (REG_AW),
            .NUM_STAGE (NUM_STAGE)
        ) u_match (
            .i_ex_rs        (ex_rs[g*REG_AW +: REG_AW]),
            .i_stg_regwrite (stg_regwrite),
            .i_stg_link     (stg_link),
            .i_stg_rd       (stg_rd),
            .o_sel          (fwd_sel[g*SELW +: SELW]),
            .o_link         (fwd_link[g])
        );
    end

    // Scoreboard lookup uses registered pending: a register frees the cycle after lat_done.
    always_comb begin
        w_lu_hit = 1'b0;
        w_sb_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i]) begin
                if (id_rs[i*REG_AW +: REG_AW] == ex_rd)
                    w_lu_hit = 1'b1;
                if ((id_rs[i*REG_AW +: REG_AW] != '0) && r_pending[id_rs[i*REG_AW +: REG_AW]])
                    w_sb_hit = 1'b1;
            end
        end
        w_lu_hit = w_lu_hit & id_valid & ex_memread & ex_regwrite & (ex_rd != '0);
        w_sb_hit = w_sb_hit & id_valid;
    end

    assign w_lu_term   = w_lu_hit | (r_state == LU_WAIT);
    assign w_stall     = (w_lu_term | w_sb_hit) & ~flush;
    assign stall       = w_stall;
    assign stall_cause = flush ? CAUSE_NONE
                               : ((w_lu_term ? CAUSE_LOAD : CAUSE_NONE) |
                                  (w_sb_hit  ? CAUSE_SB   : CAUSE_NONE));
    assign stall_cnt   = r_stall_cnt;

    // The detect cycle is the first stall cycle, so LU_WAIT covers the remaining LOAD_LAT-1.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        if (flush) begin
            w_state_nxt = IDLE;
            w_wait_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_lu_hit && (LOAD_LAT > 1)) begin
                        w_state_nxt = LU_WAIT;
                        w_wait_nxt  = WCW'(LOAD_LAT - 1);
                    end
                end
                LU_WAIT: begin
                    if (r_wait_cnt == WCW'(1)) begin
                        w_state_nxt = IDLE;
                        w_wait_nxt  = '0;
                    end else begin
                        w_wait_nxt  = r_wait_cnt - WCW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_wait_nxt  = '0;
                end
            endcase
        end
    end

    // Issue is applied after done so a same-register set and clear leaves the bit set.
    always_comb begin
        w_pending_nxt = r_pending;
        if (lat_done)
            w_pending_nxt[lat_done_rd] = 1'b0;
        if (lat_issue && (lat_rd != '0))
            w_pending_nxt[lat_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_pending   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_pending  <= w_pending_nxt;
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule
